// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM states,
// per-digit compare result and counter sizing.
package serial_magnitude_comparator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cmp_state_e;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } digit_cmp_t;

    // Digit counter width; a single-digit operand still needs one bit.
    function automatic int cnt_width(input int n_digits);
        return (n_digits <= 1) ? 1 : $clog2(n_digits);
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_twobit.sv
// Two-bit unsigned comparator slice; the same cell used in the parallel
// comparator tree, here applied to one MSB-first digit pair per cycle.
module twobit_comparator
    import serial_magnitude_comparator_pkg::*;
(
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output digit_cmp_t o_res
);

    logic w_hi_eq;
    logic w_lo_eq;

    assign w_hi_eq = ~(i_a[1] ^ i_b[1]);
    assign w_lo_eq = ~(i_a[0] ^ i_b[0]);

    // High bit decides unless equal, then the low bit decides.
    assign o_res.gt = (i_a[1] & ~i_b[1]) | (w_hi_eq & i_a[0] & ~i_b[0]);
    assign o_res.lt = (~i_a[1] & i_b[1]) | (w_hi_eq & ~i_a[0] & i_b[0]);
    assign o_res.eq = w_hi_eq & w_lo_eq;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial unsigned magnitude comparator: latches A/B on start, compares
// one 2-bit digit pair per clock MSB-first, exits early on the first difference.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             a_less_b,
    output logic             a_greater_b
);

    localparam int N     = WIDTH / 2;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    cmp_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_lt;
    logic             r_gt;

    digit_cmp_t       w_digit;
    logic             w_last;

    twobit_comparator u_digit (
        .i_a   (r_a[WIDTH-1 -: 2]),
        .i_b   (r_b[WIDTH-1 -: 2]),
        .o_res (w_digit)
    );

    assign w_last = (r_cnt == LAST_DIGIT);

    // NOTE: state is updated with non-blocking assignments only, so every
    // branch below sees the pre-edge values of r_a/r_b/r_cnt regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_gt    <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so it can only ever be a single-cycle pulse.
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_cnt   <= '0;
                        r_eq    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_gt    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_digit.gt || w_digit.lt || w_last) begin
                        r_gt    <= w_digit.gt;
                        r_lt    <= w_digit.lt;
                        r_eq    <= w_digit.eq;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_a   <= r_a << 2;
                        r_b   <= r_b << 2;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign eq          = r_eq;
    assign a_less_b    = r_lt;
    assign a_greater_b = r_gt;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench: WIDTH=2/8/16 instances driven with directed and random
// operands, checked against an arithmetic model of result and latency.
module tb_serial_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  st;
    logic [15:0] opa [3];
    logic [15:0] opb [3];
    logic [2:0]  busy_v, done_v, eq_v, lt_v, gt_v;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .start(st[0]), .A(opa[0][1:0]), .B(opb[0][1:0]),
        .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]),
        .a_less_b(lt_v[0]), .a_greater_b(gt_v[0])
    );

    serial_magnitude_comparator #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(st[1]), .A(opa[1][7:0]), .B(opb[1][7:0]),
        .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]),
        .a_less_b(lt_v[1]), .a_greater_b(gt_v[1])
    );

    serial_magnitude_comparator #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start(st[2]), .A(opa[2]), .B(opb[2]),
        .busy(busy_v[2]), .done(done_v[2]), .eq(eq_v[2]),
        .a_less_b(lt_v[2]), .a_greater_b(gt_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int width_of(input int idx);
        case (idx)
            0:       return 2;
            1:       return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] mask_of(input int w);
        logic [16:0] m;
        m = (17'h1 << w) - 17'h1;
        return m[15:0];
    endfunction

    // Done latency: index of the first differing 2-bit digit counted from the MSB, plus one.
    function automatic int exp_lat(input int w, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        x = (a ^ b) & mask_of(w);
        if (x == 16'h0) return w / 2;
        for (int i = 15; i >= 0; i--)
            if (x[i]) return (w - 1 - i) / 2 + 1;
        return w / 2;
    endfunction

    function automatic logic [2:0] exp_res(input int w, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] am, bm;
        am = a & mask_of(w);
        bm = b & mask_of(w);
        return {am == bm, am < bm, am > bm};
    endfunction

    function automatic logic [2:0] got_res(input int idx);
        return {eq_v[idx], lt_v[idx], gt_v[idx]};
    endfunction

    task automatic start_op(input int idx, input logic [15:0] a, input logic [15:0] b);
        int w;
        w = width_of(idx);
        st[idx]  = 1'b1;
        opa[idx] = a & mask_of(w);
        opb[idx] = b & mask_of(w);
        @(posedge clk); #1;
        st[idx] = 1'b0;
        check($sformatf("w%0d busy after start %h/%h", w, a, b), 32'(busy_v[idx]), 32'd1);
        check($sformatf("w%0d results cleared %h/%h", w, a, b), 32'({done_v[idx], got_res(idx)}), 32'd0);
    endtask

    // poke: drive a fresh (equal-operand) start on every busy cycle; it must be ignored.
    task automatic wait_done(input int idx, input logic [15:0] a, input logic [15:0] b, input bit poke);
        int w, lat;
        bit seen;
        w    = width_of(idx);
        lat  = 0;
        seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (poke) begin
                st[idx]  = 1'b1;
                opa[idx] = ~a & mask_of(w);
                opb[idx] = ~a & mask_of(w);
            end
            @(posedge clk); #1;
            if (poke) st[idx] = 1'b0;
            if (done_v[idx]) begin
                lat  = n;
                seen = 1'b1;
                break;
            end
            check($sformatf("w%0d busy mid-run %h/%h", w, a, b), 32'(busy_v[idx]), 32'd1);
        end
        if (!seen) begin
            check($sformatf("w%0d done timeout %h/%h", w, a, b), 32'd0, 32'd1);
        end else begin
            check($sformatf("w%0d latency %h/%h", w, a, b), 32'(lat), 32'(exp_lat(w, a, b)));
            check($sformatf("w%0d busy at done %h/%h", w, a, b), 32'(busy_v[idx]), 32'd0);
            check($sformatf("w%0d result %h/%h", w, a, b), 32'(got_res(idx)), 32'(exp_res(w, a, b)));
        end
    endtask

    task automatic check_hold(input int idx, input logic [15:0] a, input logic [15:0] b);
        int w;
        w = width_of(idx);
        @(posedge clk); #1;
        check($sformatf("w%0d idle after done %h/%h", w, a, b), 32'({busy_v[idx], done_v[idx]}), 32'd0);
        check($sformatf("w%0d result held %h/%h", w, a, b), 32'(got_res(idx)), 32'(exp_res(w, a, b)));
    endtask

    task automatic run(input int idx, input logic [15:0] a, input logic [15:0] b);
        start_op(idx, a, b);
        wait_done(idx, a, b, 1'b0);
        check_hold(idx, a, b);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int w;

        rst = 1'b1;
        st  = '0;
        for (int i = 0; i < 3; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("w%0d reset outputs", width_of(i)),
                  32'({busy_v[i], done_v[i], got_res(i)}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Equal, MSB-digit difference, LSB-digit difference on every width.
        for (int i = 0; i < 3; i++) begin
            run(i, 16'h00A5, 16'h00A5);
            run(i, 16'h0080, 16'h007F);
            run(i, 16'h0012, 16'h0013);
        end
        run(2, 16'h8000, 16'h7FFF);
        run(2, 16'h1234, 16'h1235);

        // start while busy is ignored.
        start_op(1, 16'h00, 16'hFF);
        wait_done(1, 16'h00, 16'hFF, 1'b1);
        check_hold(1, 16'h00, 16'hFF);

        // Mid-run reset drops the compare immediately.
        start_op(1, 16'h01, 16'h02);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("w8 async reset outputs", 32'({busy_v[1], done_v[1], got_res(1)}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            check("w8 no done after reset", 32'({busy_v[1], done_v[1]}), 32'd0);
        end
        run(1, 16'h01, 16'h02);

        // Back-to-back: new start in the done cycle.
        start_op(1, 16'h33, 16'h35);
        wait_done(1, 16'h33, 16'h35, 1'b0);
        start_op(1, 16'hF0, 16'h0F);
        wait_done(1, 16'hF0, 16'h0F, 1'b0);
        check_hold(1, 16'hF0, 16'h0F);

        // Random operands, biased toward equal and single-bit differences.
        for (int i = 0; i < 3; i++) begin
            w = width_of(i);
            for (int k = 0; k < 30; k++) begin
                ra = 16'($urandom);
                case ($urandom_range(0, 2))
                    0:       rb = ra;
                    1:       rb = ra ^ (16'h1 << $urandom_range(0, w - 1));
                    default: rb = 16'($urandom);
                endcase
                start_op(i, ra, rb);
                wait_done(i, ra, rb, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) check_hold(i, ra, rb);
            end
            check_hold(i, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
